master_burst_rx_port: RTL

- Parametrised successor to the master-side serial receive port.
- Deserialises single or burst read data arriving from the slave/bus side, now over LANES parallel serial lines with selectable bit order.
- Completed words go into an internal FIFO that the master core drains with a valid/ready handshake.
- Sits between the bus read path and the master core; back-pressures the slave through master_ready when the FIFO is full.

---
 rtl/master_burst_rx_port.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/master_burst_rx_port.sv
// master_burst_rx_port: multi-lane serial read-data deserialiser feeding a small FIFO
// toward the master core; back-pressures the slave through master_ready.
`timescale 1ns/1ps
module master_burst_rx_port #(
  parameter int WORD_SIZE  = 8,
  parameter int BURST_SIZE = 12,
  parameter int LANES      = 1,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_done,
  input  logic [LANES-1:0]              rx_data,
  input  logic                          slave_valid,
  input  logic [1:0]                    instruction,
  input  logic [BURST_SIZE-1:0]         burst_num,
  output logic [WORD_SIZE-1:0]          data,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          new_rx,
  output logic                          rx_done,
  output logic                          rx_error,
  output logic                          master_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BEATS = WORD_SIZE / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW    = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_HS, RECV} state_t;

  state_t                 state, state_next;
  logic [BW-1:0]          beat_cnt, beat_idx;
  logic [BURST_SIZE-1:0]  burst_cnt, burst_len;
  logic [WORD_SIZE-1:0]   word_buf, assembled;
  logic [IW-1:0]          beat_base;
  logic                   start, sample, push, abort, last_word;

  logic [WORD_SIZE-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr, rd_next;
  logic                   pop;

  assign master_ready = (state != RECV) && (fifo_level < LW'(FIFO_DEPTH));
  assign data_valid   = (fifo_level != '0);
  assign pop          = data_ready && data_valid;
  assign rd_next      = pop ? rd_ptr + PW'(1) : rd_ptr;
  assign beat_idx     = (state == RECV) ? beat_cnt : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    sample     = 1'b0;
    push       = 1'b0;
    abort      = 1'b0;
    last_word  = 1'b0;
    case (state)
      IDLE: begin
        if (instruction == 2'b11 && tx_done) begin
          start      = 1'b1;
          state_next = WAIT_HS;
        end
      end
      WAIT_HS: begin
        if (instruction != 2'b11) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (slave_valid && master_ready) begin
          sample = 1'b1;
          if (BEATS == 1) push = 1'b1;
          else            state_next = RECV;
        end
      end
      RECV: begin
        if (instruction != 2'b11) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else begin
          sample = 1'b1;
          if (beat_cnt == BW'(BEATS - 1)) push = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (push) begin
      last_word  = (burst_cnt == burst_len);
      state_next = last_word ? IDLE : WAIT_HS;
    end
  end

  // Merge the beat on rx_data into the partial word at its bit-order position.
  always_comb begin
    if (MSB_FIRST) beat_base = IW'(WORD_SIZE - (int'(beat_idx) + 1) * LANES);
    else           beat_base = IW'(int'(beat_idx) * LANES);
    assembled = word_buf;
    assembled[beat_base +: LANES] = rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      burst_len <= '0;
      word_buf  <= '0;
      new_rx    <= 1'b0;
      rx_done   <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      new_rx   <= push;
      rx_done  <= push && last_word;
      rx_error <= abort;
      if (start) begin
        burst_cnt <= '0;
        burst_len <= burst_num;
      end else if (push && !last_word) begin
        burst_cnt <= burst_cnt + BURST_SIZE'(1);
      end
      if (push || abort) beat_cnt <= '0;
      else if (sample)   beat_cnt <= beat_cnt + BW'(1);
      if (sample) word_buf <= assembled;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= assembled;
  end

  // data holds the head: the word being written takes it when it lands in an empty slot ahead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      data       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (push && (rd_next == wr_ptr)) data <= assembled;
      else if (pop)                    data <= mem[rd_next];
    end
  end

endmodule
